mux_share_arbiter: RTL and testbench

Round-robin arbiter that shares one 4:1 select-driven mux datapath among three requesters. It generates the registered 2-bit mux select, a one-hot grant and a valid flag. Each grant lasts until the owner drops its request or a hold limit expires while others wait. It sits directly in front of the mux select input. Select code 2'b11 is reserved as the idle/parked code.

---
 rtl/mux_share_arbiter_if.sv | 11 +
 rtl/mux_share_arbiter.sv | 79 +++++++
 tb/tb_mux_share_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/mux_share_arbiter_if.sv
// mux_share_arbiter_if: request/grant bundle between requesters and the shared-mux arbiter.
interface mux_share_arbiter_if #(parameter int CNT_W = 4);
  logic [2:0]       req;
  logic [2:0]       gnt;
  logic [1:0]       sel;
  logic             valid;
  logic             preempt;
  logic [CNT_W-1:0] hold_cnt;
  modport master (output req, input gnt, sel, valid, preempt, hold_cnt);
  modport slave  (input req, output gnt, sel, valid, preempt, hold_cnt);
endinterface

// File: rtl/mux_share_arbiter.sv
// mux_share_arbiter: round-robin owner of a 4:1 mux among three requesters, with hold limit
// and optional parked turnaround cycle (sel=2'b11) between owners.
module mux_share_arbiter #(
  parameter int HOLD_MAX   = 8,
  parameter int CNT_W      = 4,
  parameter bit TURNAROUND = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  mux_share_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d, last_q, last_d, win;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             pre_q, pre_d, any_req, mine, others, expired;
  function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] l);
    logic [1:0] n1, n2;
    n1 = (l == 2'd2) ? 2'd0 : l + 2'd1;
    n2 = (n1 == 2'd2) ? 2'd0 : n1 + 2'd1;
    return r[n1] ? n1 : r[n2] ? n2 : l;
  endfunction
  assign any_req = |bus.req;
  assign win     = pick(bus.req, last_q);
  assign mine    = bus.req[owner_q];
  assign others  = |(bus.req & ~(3'b001 << owner_q));
  assign expired = hold_q == CNT_W'(HOLD_MAX);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd2;
      hold_q  <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      pre_q   <= pre_d;
    end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    pre_d   = 1'b0;
    unique case (state_q)
      GRANT:
        if (mine && !expired) hold_d = hold_q + 1'b1;
        else if (mine && !others) hold_d = CNT_W'(1);
        else begin
          pre_d  = mine;
          hold_d = '0;
          // Without turnaround, re-arbitrate on the release edge; last_q==owner_q puts the old owner last.
          if (TURNAROUND) state_d = GAP;
          else if (any_req) begin
            owner_d = win;
            last_d  = win;
            hold_d  = CNT_W'(1);
          end else state_d = IDLE;
        end
      default:
        if (any_req) begin
          state_d = GRANT;
          owner_d = win;
          last_d  = win;
          hold_d  = CNT_W'(1);
        end else state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.valid    = state_q == GRANT;
    bus.gnt      = bus.valid ? 3'b001 << owner_q : 3'b000;
    bus.sel      = bus.valid ? owner_q : 2'b11;
    bus.preempt  = pre_q;
    bus.hold_cnt = hold_q;
  end
endmodule

// File: tb/tb_mux_share_arbiter.sv
// tb_mux_share_arbiter: scoreboarded random/directed bench for two configurations
// (HOLD_MAX=8 with turnaround, HOLD_MAX=3 back-to-back) driven by the same requests.
module tb_mux_share_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mux_share_arbiter_if #(.CNT_W(4)) ia(), ib();
  mux_share_arbiter #(.HOLD_MAX(8), .CNT_W(4), .TURNAROUND(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  mux_share_arbiter #(.HOLD_MAX(3), .CNT_W(4), .TURNAROUND(1'b0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
  int own[2], cnt[2], last[2];
  bit pre[2];
  int hm[2] = '{8, 3};
  bit ta[2] = '{1'b1, 1'b0};
  logic [11:0] qa[$], qb[$];
  localparam logic [11:0] RST_V = {3'b000, 2'b11, 1'b0, 1'b0, 4'd0};
  function automatic int rr(input logic [2:0] r, input int l);
    for (int k = 1; k <= 3; k++) begin
      int i = (l + k) % 3;
      if (r[i]) return i;
    end
    return -1;
  endfunction
  function automatic logic [11:0] expv(input int m);
    if (own[m] >= 0) return {3'(1 << own[m]), 2'(own[m]), 1'b1, pre[m], 4'(cnt[m])};
    return {3'b000, 2'b11, 1'b0, pre[m], 4'(cnt[m])};
  endfunction
  task automatic grant_to(input int m, input int w);
    own[m] = w;
    last[m] = w;
    cnt[m] = 1;
  endtask
  task automatic step(input int m, input logic [2:0] r);
    int w;
    pre[m] = 1'b0;
    if (own[m] < 0) begin
      w = rr(r, last[m]);
      if (w >= 0) grant_to(m, w);
    end else if (r[own[m]] && cnt[m] < hm[m]) cnt[m]++;
    else if (r[own[m]] && (r & ~(3'b001 << own[m])) == 3'b000) cnt[m] = 1;
    else begin
      pre[m] = r[own[m]];
      w = own[m];
      own[m] = -1;
      cnt[m] = 0;
      if (!ta[m]) begin
        w = rr(r, w);
        if (w >= 0) grant_to(m, w);
      end
    end
  endtask
  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      own[m] = -1;
      cnt[m] = 0;
      last[m] = 2;
      pre[m] = 1'b0;
    end
  endtask
  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got gnt/sel/valid/preempt/hold=%b want %b", name, $time, act, exp);
    end
  endtask
  task automatic cyc_now(input logic [2:0] r);
    ia.req = r;
    ib.req = r;
    step(0, r);
    step(1, r);
    qa.push_back(expv(0));
    qb.push_back(expv(1));
  endtask
  task automatic cyc(input logic [2:0] r);
    @(negedge clk);
    cyc_now(r);
  endtask
  task automatic seq(input logic [2:0] r, input int n);
    repeat (n) cyc(r);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_a", {ia.gnt, ia.sel, ia.valid, ia.preempt, ia.hold_cnt}, RST_V);
    chk("async_reset_b", {ib.gnt, ib.sel, ib.valid, ib.preempt, ib.hold_cnt}, RST_V);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc_now(3'b000);
  endtask
  always @(posedge clk) begin
    #1;
    if (rst_n && qa.size() > 0) chk("cfg_a", {ia.gnt, ia.sel, ia.valid, ia.preempt, ia.hold_cnt}, qa.pop_front());
    if (rst_n && qb.size() > 0) chk("cfg_b", {ib.gnt, ib.sel, ib.valid, ib.preempt, ib.hold_cnt}, qb.pop_front());
  end
  initial begin
    logic [2:0] r;
    ia.req = 3'b000;
    ib.req = 3'b000;
    model_reset();
    #12;
    chk("reset_a", {ia.gnt, ia.sel, ia.valid, ia.preempt, ia.hold_cnt}, RST_V);
    chk("reset_b", {ib.gnt, ib.sel, ib.valid, ib.preempt, ib.hold_cnt}, RST_V);
    @(negedge clk);
    rst_n = 1'b1;
    cyc_now(3'b000);
    seq(3'b001, 3);
    seq(3'b000, 3);
    for (int i = 0; i < 4; i++) begin
      seq(3'b111, 2);
      seq(3'b111 & ~(3'b001 << (i % 3)), 1);
    end
    seq(3'b000, 2);
    seq(3'b011, 12);
    seq(3'b000, 2);
    seq(3'b100, 20);
    seq(3'b000, 2);
    seq(3'b110, 3);
    seq(3'b100, 3);
    seq(3'b000, 2);
    seq(3'b001, 2);
    do_reset();
    seq(3'b111, 3);
    r = 3'b000;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) r = 3'($urandom_range(0, 7));
      cyc(r);
      if (i == 400) do_reset();
    end
    seq(3'b000, 2);
    for (int i = 0; i < 10 && (qa.size() + qb.size()) > 0; i++) @(posedge clk);
    #2;
    chk("drain", 12'(qa.size() + qb.size()), 12'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
